// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pwm_multi PWM generator.
// Optional build macro: PWM_CENTER_ALIGN_EN selects the up/down (centre-aligned)
// counter; when it is undefined the counter is an edge-aligned sawtooth.
package pwm_pkg;

    // Counting direction of the centre-aligned counter
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Terminal count of a WIDTH-bit period counter (2**WIDTH - 1)
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty shadow pair with load bypass,
// unsigned comparator against the shared counter and a registered output.
// Behaviour does not depend on PWM_CENTER_ALIGN_EN; the top decides when
// i_commit fires and what count value is presented.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_commit,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic [WIDTH-1:0] w_next_pending;

    // A strobe in the same cycle as a commit must reach active directly,
    // so commit copies the post-load pending value rather than r_pending.
    always_comb begin
        w_next_pending = i_load ? i_duty : r_pending;
    end

    // Shadow pair: pending follows loads, active follows pending at commit or while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_active  <= '0;
        end else begin
            r_pending <= w_next_pending;
            if (i_commit || !i_enable) begin
                r_active <= w_next_pending;
            end
        end
    end

    // Registered compare output, forced low while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= i_enable && (r_active > i_count);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one free-running period counter.
// Duty words are strobed into per-channel shadow registers and committed at
// the period boundary so an update never produces a truncated or stretched pulse.
// Optional build macro: PWM_CENTER_ALIGN_EN -> up/down counter with each
// endpoint held for two cycles (period 2**(WIDTH+1)); undefined -> sawtooth.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic [CHANNELS-1:0]       duty_load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0]    r_count;
    logic                r_tick;
    logic                w_commit;
    logic                w_tick_next;
    logic [CHANNELS-1:0] w_pwm;

`ifdef PWM_CENTER_ALIGN_EN
    dir_e r_dir;

    // Triangle counter: the turn-around cycle only flips direction, which
    // holds both endpoints for two consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_dir   <= DIR_UP;
        end else if (!enable) begin
            r_count <= '0;
            r_dir   <= DIR_UP;
        end else if (r_dir == DIR_UP) begin
            if (r_count == CNT_MAX) begin
                r_dir <= DIR_DOWN;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                r_dir <= DIR_UP;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Commit on the last cycle of the period (bottom, going down); tick on the first
    always_comb begin
        w_commit    = enable && (r_count == '0) && (r_dir == DIR_DOWN);
        w_tick_next = enable && (r_count == '0) && (r_dir == DIR_UP);
    end
`else
    // Sawtooth counter wrapping naturally from CNT_MAX to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (!enable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Commit on the last count of the period; tick on the first
    always_comb begin
        w_commit    = enable && (r_count == CNT_MAX);
        w_tick_next = enable && (r_count == '0);
    end
`endif

    // Period start pulse, registered to line up with the pwm_out of count zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_enable (enable),
            .i_commit (w_commit),
            .i_load   (duty_load[g]),
            .i_duty   (duty_in[g*WIDTH +: WIDTH]),
            .i_count  (r_count),
            .o_pwm    (w_pwm[g])
        );
    end

    assign pwm_out     = w_pwm;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4).
// Reference model tracks the phase within the period and derives the counter
// value from it (sawtooth or triangle); define PWM_CENTER_ALIGN_EN for both
// RTL and bench to exercise the centre-aligned build.
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int M  = 256;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int P  = 512;
    localparam int HF = 2;
`else
    localparam int P  = 256;
    localparam int HF = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CH*W-1:0] duty_in;
    logic [CH-1:0] duty_load;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .duty_in     (duty_in),
        .duty_load   (duty_load),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    // ---------------- reference model ----------------
    int pend [CH];
    int act  [CH];
    int kt = 0;          // period phase the counter holds at the next edge
    logic [CH-1:0] exp_out = '0;
    logic exp_tick = 1'b0;
    bit model_ok = 1'b0;

    // Counter value at a given phase of the period
    function automatic int cnt_at(input int t);
        if (P == 2*M && t >= M) return P - 1 - t;
        return t;
    endfunction

    always @(posedge clk) begin
        int np [CH];
        for (int i = 0; i < CH; i++)
            np[i] = duty_load[i] ? int'(duty_in[i*W +: W]) : pend[i];
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                pend[i] = 0;
                act[i]  = 0;
            end
            kt = 0;
            exp_out = '0;
            exp_tick = 1'b0;
        end else if (!enable) begin
            pend = np;
            act  = np;
            kt = 0;
            exp_out = '0;
            exp_tick = 1'b0;
        end else begin
            for (int i = 0; i < CH; i++)
                exp_out[i] = (act[i] > cnt_at(kt));
            exp_tick = (kt == 0);
            if (kt == P - 1) act = np;
            pend = np;
            kt = (kt + 1) % P;
        end
        model_ok = 1'b1;
    end

    // ---------------- compare process ----------------
    int tests = 0;
    int fails = 0;
    int cyc_prints = 0;
    string lit_name;
    int lit_act;
    int lit_exp;
    int lit_seq = 0;
    int lit_done = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            tests++;
            if (pwm_out !== exp_out || period_tick !== exp_tick) begin
                fails++;
                if (cyc_prints < 12) begin
                    cyc_prints++;
                    $display("FAIL cycle@%0t: pwm_out=%b period_tick=%b, required pwm_out=%b period_tick=%b",
                             $time, pwm_out, period_tick, exp_out, exp_tick);
                end
            end
        end
        if (lit_seq != lit_done) begin
            tests++;
            if (lit_act != lit_exp) begin
                fails++;
                $display("FAIL %s: got %0d, required %0d", lit_name, lit_act, lit_exp);
            end
            lit_done = lit_seq;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string name, input int a, input int e);
        lit_name = name;
        lit_act  = a;
        lit_exp  = e;
        lit_seq++;
        wait (lit_done == lit_seq);
    endtask

    task automatic wait_kt(input int t);
        int n = 0;
        while (kt != t && n < 2*P) begin
            @(negedge clk);
            n++;
        end
        if (kt != t) lit("wait_kt timeout", kt, t);
    endtask

    task automatic load(input int ch, input int d);
        duty_in[ch*W +: W] = W'(d);
        duty_load = '0;
        duty_load[ch] = 1'b1;
        @(negedge clk);
        duty_load = '0;
    endtask

    int meas_hi [CH];
    int meas_first [CH];
    int meas_tick;

    // Count high cycles per channel over one whole period starting at phase 0
    task automatic measure();
        wait_kt(1);
        meas_tick = 0;
        for (int i = 0; i < CH; i++) begin
            meas_hi[i] = 0;
            meas_first[i] = int'(pwm_out[i]);
        end
        for (int n = 0; n < P; n++) begin
            for (int i = 0; i < CH; i++) meas_hi[i] += int'(pwm_out[i]);
            meas_tick += int'(period_tick);
            @(negedge clk);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int hi1;
        rst = 1'b1;
        enable = 1'b0;
        duty_in = '0;
        duty_load = '0;
        repeat (3) @(negedge clk);
        lit("reset pwm_out", int'(pwm_out), 0);
        lit("reset period_tick", int'(period_tick), 0);

        rst = 1'b0;
        enable = 1'b1;
        measure();
        lit("duty0 ch0 high", meas_hi[0], 0);
        lit("ticks per period", meas_tick, 1);

        // duty 64 on ch0 and ch1
        load(0, 64);
        load(1, 64);
        measure();
        lit("ch0 duty64 high", meas_hi[0], 64*HF);
        lit("ch0 high at period start", meas_first[0], 1);
        lit("ch1 duty64 high", meas_hi[1], 64*HF);
        lit("tick once per period", meas_tick, 1);

        // ch1 64 -> 192 loaded mid-period at counter 100
        wait_kt(1);
        hi1 = 0;
        for (int n = 0; n < P; n++) begin
            if (kt == 100) begin
                duty_in[1*W +: W] = 8'd192;
                duty_load = 4'b0010;
            end else begin
                duty_load = '0;
            end
            hi1 += int'(pwm_out[1]);
            @(negedge clk);
        end
        duty_load = '0;
        lit("ch1 period of mid load", hi1, 64*HF);
        measure();
        lit("ch1 next period 192", meas_hi[1], 192*HF);

        // load on the commit cycle uses the new value immediately
        wait_kt(P - 1);
        load(0, 10);
        measure();
        lit("ch0 bypass duty10", meas_hi[0], 10*HF);

        // extremes
        load(2, 0);
        load(3, 255);
        measure();
        lit("ch2 duty0 high", meas_hi[2], 0);
        lit("ch3 duty255 high", meas_hi[3], 255*HF);
        lit("ch3 duty255 low", P - meas_hi[3], P - 255*HF);

        // enable dropped mid-period, duty changed while idle, restart
        wait_kt(50);
        enable = 1'b0;
        @(negedge clk);
        lit("disable pwm_out", int'(pwm_out), 0);
        lit("disable period_tick", int'(period_tick), 0);
        load(0, 200);
        repeat (3) @(negedge clk);
        lit("idle pwm_out", int'(pwm_out), 0);
        enable = 1'b1;
        measure();
        lit("restart ch0 latest duty", meas_hi[0], 200*HF);
        lit("restart ch3 high", meas_hi[3], 255*HF);
        lit("restart tick", meas_tick, 1);

        // reset mid-run
        wait_kt(30);
        rst = 1'b1;
        @(negedge clk);
        lit("midrun reset pwm_out", int'(pwm_out), 0);
        lit("midrun reset period_tick", int'(period_tick), 0);
        rst = 1'b0;
        measure();
        lit("post reset ch0 high", meas_hi[0], 0);
        lit("post reset ch3 high", meas_hi[3], 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < CH; i++) begin
                case ($urandom_range(0, 3))
                    0: duty_in[i*W +: W] = 8'd0;
                    1: duty_in[i*W +: W] = 8'd255;
                    default: duty_in[i*W +: W] = W'($urandom_range(0, 255));
                endcase
                duty_load[i] = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        enable = 1'b0;
        duty_load = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
